// File: rtl/adc_frame_buffer_if.sv
// adc_frame_buffer_if
//   Groups the frame-write, consumer-read and status signals of the ADC frame
//   buffer into one bundle.
//   master : producer/consumer side (drives frame_valid, frame_data, rd_en,
//            clr_ovf; observes head entry and status)
//   slave  : the buffer itself (the opposite directions)
`timescale 1ns/1ps
interface adc_frame_buffer_if #(
    parameter int SAMPLE_W = 12
);
    logic                frame_valid;
    logic [15:0]         frame_data;
    logic                rd_en;
    logic                clr_ovf;
    logic                rd_valid;
    logic [SAMPLE_W-1:0] rd_sample;
    logic [2:0]          rd_channel;
    logic [3:0]          level;
    logic                full;
    logic                frame_err;
    logic                overflow;
    logic [7:0]          ovf_count;

    modport master (
        output frame_valid, frame_data, rd_en, clr_ovf,
        input  rd_valid, rd_sample, rd_channel, level, full,
               frame_err, overflow, ovf_count
    );

    modport slave (
        input  frame_valid, frame_data, rd_en, clr_ovf,
        output rd_valid, rd_sample, rd_channel, level, full,
               frame_err, overflow, ovf_count
    );
endinterface

// File: rtl/adc_frame_buffer.sv
// adc_frame_buffer
//   8-entry first-word-fall-through FIFO between the SPI frame receiver and
//   the sample consumer. Each 16-bit frame {null, channel[2:0], sample[11:0]}
//   is stored as {channel, sample}; frames with a non-zero null bit are
//   discarded and flagged on frame_err. Frames arriving while full (and not
//   relieved by a same-cycle pop) are dropped and counted.
// Ports
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : adc_frame_buffer_if.slave (frame write, pop, status)
`timescale 1ns/1ps
module adc_frame_buffer #(
    parameter int DEPTH    = 8,
    parameter int SAMPLE_W = 12
) (
    input logic              clk,
    input logic              rst_n,
    adc_frame_buffer_if.slave bus
);
    localparam int          PTR_W   = $clog2(DEPTH);
    localparam int          ENTRY_W = SAMPLE_W + 3;
    localparam logic [3:0]  LVL_MAX = 4'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [3:0]         level_q;
    logic               frame_err_q;
    logic               overflow_q;
    logic [7:0]         ovf_count_q;

    logic frame_ok;
    logic frame_bad;
    logic is_full;
    logic pop;
    logic push;
    logic drop;

    assign is_full   = (level_q == LVL_MAX);
    assign frame_ok  = bus.frame_valid & ~bus.frame_data[15];
    assign frame_bad = bus.frame_valid &  bus.frame_data[15];
    assign pop       = bus.rd_en & (level_q != 4'd0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push      = frame_ok & (~is_full | bus.rd_en);
    assign drop      = frame_ok & is_full & ~bus.rd_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= 4'd0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
            ovf_count_q <= 8'd0;
        end else begin
            frame_err_q <= frame_bad;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level_q <= level_q + 4'd1;
                2'b01:   level_q <= level_q - 4'd1;
                default: level_q <= level_q;
            endcase
            // A drop in the clearing cycle counts as the first new drop.
            if (bus.clr_ovf) begin
                overflow_q  <= drop;
                ovf_count_q <= drop ? 8'd1 : 8'd0;
            end else if (drop) begin
                overflow_q <= 1'b1;
                if (ovf_count_q != 8'hFF) ovf_count_q <= ovf_count_q + 8'd1;
            end
        end
    end

    // Storage is not reset; rd_* are meaningless while rd_valid is low.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.frame_data[14:12], bus.frame_data[SAMPLE_W-1:0]};
    end

    assign bus.rd_valid   = (level_q != 4'd0);
    assign bus.rd_sample  = mem[rd_ptr][SAMPLE_W-1:0];
    assign bus.rd_channel = mem[rd_ptr][ENTRY_W-1:SAMPLE_W];
    assign bus.level      = level_q;
    assign bus.full       = is_full;
    assign bus.frame_err  = frame_err_q;
    assign bus.overflow   = overflow_q;
    assign bus.ovf_count  = ovf_count_q;
endmodule

// File: tb/tb_adc_frame_buffer.sv
`timescale 1ns/1ps
module tb_adc_frame_buffer;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    adc_frame_buffer_if bus();

    adc_frame_buffer #(.DEPTH(8), .SAMPLE_W(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain queue of {channel, sample} plus status values.
    logic [14:0] q[$];
    logic        m_err;
    logic        m_ovf;
    int          m_cnt;

    typedef struct {
        logic        fv;
        logic [15:0] fd;
        logic        re;
        logic        clr;
        int          lvl;
        logic        vld;
        int          ch;
        int          smp;
        logic        err;
        logic        ovf;
        int          cnt;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_err = 1'b0;
        m_ovf = 1'b0;
        m_cnt = 0;
    endtask

    // One clock with the current inputs; model advanced, outputs compared after the edge.
    task automatic cycle();
        logic ok, popm, wasfull, dropm;
        ok      = bus.frame_valid && !bus.frame_data[15];
        wasfull = (q.size() == 8);
        popm    = bus.rd_en && (q.size() > 0);
        dropm   = ok && wasfull && !bus.rd_en;
        if (popm) void'(q.pop_front());
        if (ok && !dropm) q.push_back(bus.frame_data[14:0]);
        m_err = bus.frame_valid && bus.frame_data[15];
        if (bus.clr_ovf) begin
            m_ovf = 1'b0;
            m_cnt = 0;
        end
        if (dropm) begin
            m_ovf = 1'b1;
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        end
        @(posedge clk);
        #1;
        chk("level",     32'(bus.level),     32'(q.size()));
        chk("rd_valid",  32'(bus.rd_valid),  32'(q.size() > 0));
        chk("full",      32'(bus.full),      32'(q.size() == 8));
        chk("frame_err", 32'(bus.frame_err), 32'(m_err));
        chk("overflow",  32'(bus.overflow),  32'(m_ovf));
        chk("ovf_count", 32'(bus.ovf_count), 32'(m_cnt));
        if (q.size() > 0) begin
            chk("rd_channel", 32'(bus.rd_channel), 32'(q[0][14:12]));
            chk("rd_sample",  32'(bus.rd_sample),  32'(q[0][11:0]));
        end
    endtask

    task automatic drive(input logic fv, input logic [15:0] fd, input logic re, input logic clr);
        bus.frame_valid = fv;
        bus.frame_data  = fd;
        bus.rd_en       = re;
        bus.clr_ovf     = clr;
        cycle();
        bus.frame_valid = 1'b0;
        bus.frame_data  = 16'h0000;
        bus.rd_en       = 1'b0;
        bus.clr_ovf     = 1'b0;
    endtask

    // Asynchronous reset between edges, outputs checked before any edge.
    task automatic async_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_level",     32'(bus.level),     0);
        chk("rst_rd_valid",  32'(bus.rd_valid),  0);
        chk("rst_full",      32'(bus.full),      0);
        chk("rst_frame_err", 32'(bus.frame_err), 0);
        chk("rst_overflow",  32'(bus.overflow),  0);
        chk("rst_ovf_count", 32'(bus.ovf_count), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic fill8();
        for (int i = 0; i < 8; i++)
            drive(1'b1, {1'b0, 3'(i), 12'(i * 16 + 1)}, 1'b0, 1'b0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.frame_valid = 1'b0;
        bus.frame_data  = 16'h0000;
        bus.rd_en       = 1'b0;
        bus.clr_ovf     = 1'b0;
        model_reset();

        //           fv    fd        re    clr   lvl vld  ch smp     err   ovf cnt
        vecs[0] = '{1'b1, 16'h3ABC, 1'b0, 1'b0, 1, 1'b1, 3, 'hABC, 1'b0, 1'b0, 0};
        vecs[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0, 0, 0,     1'b0, 1'b0, 0};
        vecs[2] = '{1'b1, 16'h8123, 1'b0, 1'b0, 0, 1'b0, 0, 0,     1'b1, 1'b0, 0};
        vecs[3] = '{1'b0, 16'h0000, 1'b0, 1'b0, 0, 1'b0, 0, 0,     1'b0, 1'b0, 0};
        vecs[4] = '{1'b1, 16'h5001, 1'b0, 1'b0, 1, 1'b1, 5, 'h001, 1'b0, 1'b0, 0};
        vecs[5] = '{1'b1, 16'h2FFF, 1'b1, 1'b0, 1, 1'b1, 2, 'hFFF, 1'b0, 1'b0, 0};
        vecs[6] = '{1'b1, 16'h8FFF, 1'b1, 1'b0, 0, 1'b0, 0, 0,     1'b1, 1'b0, 0};
        vecs[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0, 0, 0,     1'b0, 1'b0, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("init_level",    32'(bus.level),     0);
        chk("init_rd_valid", 32'(bus.rd_valid),  0);
        chk("init_overflow", 32'(bus.overflow),  0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].fv, vecs[i].fd, vecs[i].re, vecs[i].clr);
            chk($sformatf("vec%0d_level", i),     32'(bus.level),     32'(vecs[i].lvl));
            chk($sformatf("vec%0d_rd_valid", i),  32'(bus.rd_valid),  32'(vecs[i].vld));
            chk($sformatf("vec%0d_frame_err", i), 32'(bus.frame_err), 32'(vecs[i].err));
            chk($sformatf("vec%0d_overflow", i),  32'(bus.overflow),  32'(vecs[i].ovf));
            chk($sformatf("vec%0d_ovf_count", i), 32'(bus.ovf_count), 32'(vecs[i].cnt));
            if (vecs[i].vld) begin
                chk($sformatf("vec%0d_channel", i), 32'(bus.rd_channel), 32'(vecs[i].ch));
                chk($sformatf("vec%0d_sample", i),  32'(bus.rd_sample),  32'(vecs[i].smp));
            end
        end

        // Fill then three drops, then drain in order.
        fill8();
        for (int i = 0; i < 3; i++) drive(1'b1, 16'h7777, 1'b0, 1'b0);
        chk("fill_full",      32'(bus.full),      1);
        chk("fill_level",     32'(bus.level),     8);
        chk("fill_overflow",  32'(bus.overflow),  1);
        chk("fill_ovf_count", 32'(bus.ovf_count), 3);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d_channel", i), 32'(bus.rd_channel), 32'(i));
            chk($sformatf("drain%0d_sample", i),  32'(bus.rd_sample),  32'(i * 16 + 1));
            drive(1'b0, 16'h0000, 1'b1, 1'b0);
        end
        chk("drain_level", 32'(bus.level), 0);
        drive(1'b0, 16'h0000, 1'b0, 1'b1);
        chk("clr_overflow", 32'(bus.overflow), 0);

        // Push and pop together while full.
        fill8();
        drive(1'b1, 16'h1EEE, 1'b1, 1'b0);
        chk("pp_level",    32'(bus.level),    8);
        chk("pp_overflow", 32'(bus.overflow), 0);
        for (int i = 0; i < 7; i++) drive(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("pp_new_channel", 32'(bus.rd_channel), 1);
        chk("pp_new_sample",  32'(bus.rd_sample),  'hEEE);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);

        // Malformed frame on a non-empty FIFO.
        drive(1'b1, 16'h4321, 1'b0, 1'b0);
        drive(1'b1, 16'h8123, 1'b0, 1'b0);
        chk("bad_err_pulse", 32'(bus.frame_err), 1);
        chk("bad_level",     32'(bus.level),     1);
        chk("bad_overflow",  32'(bus.overflow),  0);
        drive(1'b0, 16'h0000, 1'b0, 1'b0);
        chk("bad_err_clear", 32'(bus.frame_err), 0);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);

        // Saturation, then clear coincident with a drop.
        fill8();
        for (int i = 0; i < 260; i++) drive(1'b1, 16'h0555, 1'b0, 1'b0);
        chk("sat_ovf_count", 32'(bus.ovf_count), 255);
        drive(1'b1, 16'h0555, 1'b0, 1'b1);
        chk("clrdrop_overflow",  32'(bus.overflow),  1);
        chk("clrdrop_ovf_count", 32'(bus.ovf_count), 1);

        // Async reset with level 5.
        for (int i = 0; i < 3; i++) drive(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("pre_rst_level", 32'(bus.level), 5);
        async_reset();
        drive(1'b1, 16'h6123, 1'b0, 1'b0);
        chk("post_rst_level",   32'(bus.level),      1);
        chk("post_rst_channel", 32'(bus.rd_channel), 6);
        chk("post_rst_sample",  32'(bus.rd_sample),  'h123);
        drive(1'b0, 16'h0000, 1'b1, 1'b0);

        // Pointer wrap across 20 push/pop pairs.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, {1'b0, 3'(i), 12'(i * 97)}, 1'b0, 1'b0);
            chk($sformatf("wrap%0d_channel", i), 32'(bus.rd_channel), 32'(i % 8));
            chk($sformatf("wrap%0d_sample", i),  32'(bus.rd_sample),  32'((i * 97) % 4096));
            drive(1'b0, 16'h0000, 1'b1, 1'b0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] fd;
            fd     = 16'($urandom);
            fd[15] = ($urandom_range(0, 9) == 0);
            drive($urandom_range(0, 1) == 1, fd,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/adc_frame_buffer.md
ADC_FRAME_BUFFER -- requirements
Module: adc_frame_buffer

Interface
- REQ-001: Parameter DEPTH, 8, FIFO entry count; fixed power of two; only 8 supported.
- REQ-002: Parameter SAMPLE_W, 12, sample field width inside the 16-bit SPI frame.
- REQ-003: clk  input  1  single system clock; all state updates on its rising edge.
- REQ-004: rst_n  input  1  asynchronous, active-low reset.
- REQ-005: frame_valid  input  1  one-cycle strobe from the SPI interface stage marking a completed 16-bit frame.
- REQ-006: frame_data  input  16  received frame; sampled only when frame_valid=1.
- REQ-007: rd_en  input  1  consumer pop request.
- REQ-008: clr_ovf  input  1  one-cycle clear of the overflow status.
- REQ-009: rd_valid  output  1  FIFO non-empty; rd_sample and rd_channel are meaningful.
- REQ-010: rd_sample  output  12  head-entry sample, first-word-fall-through.
- REQ-011: rd_channel  output  3  head-entry channel number.
- REQ-012: level  output  4  current occupancy, 0..8.
- REQ-013: full  output  1  level==8.
- REQ-014: frame_err  output  1  one-cycle pulse when a malformed frame is discarded.
- REQ-015: overflow  output  1  sticky flag: a valid frame was dropped because the FIFO was full.
- REQ-016: ovf_count  output  8  count of dropped frames, saturating at 255.

Function
- REQ-017: Frame format:
  - bit15 = 0 (leading null bit)
  - bits[14:12] = channel
  - bits[11:0] = sample, MSB first as shifted
- REQ-018: Write conditions when frame_valid=1:
  - bit15=1: frame is not written; frame_err pulses high the next cycle; no other state changes.
- REQ-019: Write conditions when frame_valid=1 and bit15=0:
  - full=0: {channel, sample} is written at wr_ptr; wr_ptr increments.
  - full=1 and rd_en=1: the write also succeeds.
  - full=1 and rd_en=0: the frame is dropped.
- REQ-020: Pop occurs when rd_en=1 and rd_valid=1; rd_ptr increments.
- REQ-021: rd_en while empty is ignored, with no pointer or level change.
- REQ-022: rd_sample and rd_channel are driven combinationally from mem[rd_ptr].
  - A written entry is visible on rd_* the cycle after the write edge.
  - No write-to-read bypass on an empty FIFO.
- REQ-023: Simultaneous push and pop (including at full) leaves level unchanged and advances both pointers.
- REQ-024: Pointers are 3 bits and wrap 7->0 with no gap; level is tracked by a separate 4-bit counter.
- REQ-025: Level update per edge:
  - push only: +1
  - pop only: -1
  - both or neither: unchanged
  - Never below 0 or above 8.
- REQ-026: Dropped frame handling:
  - overflow is set to 1.
  - ovf_count increments unless it is already 255, in which case it holds.
- REQ-027: clr_ovf=1 clears overflow to 0 and ovf_count to 0.
  - If a drop occurs in the same cycle, overflow=1 and ovf_count=1 after the edge.
- REQ-028: frame_err and overflow are independent; a malformed frame never counts as overflow.
- REQ-029: Latency: frame_valid edge to rd_valid=1 on an empty FIFO is exactly 1 clock.

Reset
- REQ-030: rst_n=0 immediately, without waiting for a clock edge, forces the following to 0: wr_ptr, rd_ptr, level, rd_valid, full, frame_err, overflow, ovf_count.
- REQ-031: Memory contents are not reset.
  - rd_sample and rd_channel are don't-care while rd_valid=0.
- REQ-032: A frame_valid coincident with the rst_n release edge is ignored.
- REQ-033: Reset asserted mid-operation discards all stored entries.
  - The first frame after release lands in entry 0.

Verification
- REQ-034: Single frame: frame_data=16'h3ABC with frame_valid pulse.
  - Next cycle: rd_valid=1, rd_channel=3, rd_sample=12'hABC, level=1.
  - After rd_en: level=0, rd_valid=0.
- REQ-035: Fill and overflow: write 8 frames with channels 0..7, then 3 more with rd_en=0.
  - full=1, level=8, overflow=1, ovf_count=3.
  - Reads return channels 0..7 in order.
- REQ-036: Push+pop at full: with level=8, pulse frame_valid and rd_en together.
  - level stays 8, overflow stays 0.
  - The new frame emerges after 7 further pops.
- REQ-037: Malformed frame: frame_data=16'h8123.
  - frame_err pulses for 1 cycle.
  - level and overflow unchanged.
- REQ-038: Saturation/clear:
  - 260 drops while full -> ovf_count=255.
  - clr_ovf coincident with a drop -> overflow=1, ovf_count=1.
- REQ-039: Async reset: assert rst_n=0 between clock edges with level=5.
  - All outputs listed in REQ-030 read 0 before the next edge.
  - Pointer wrap is checked across 20 sequential push/pop pairs.
